// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan-tested multiplier controller.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPT,
    FULL,
    UNLOAD
  } scan_state_e;

  localparam logic [63:0] MISR_POLY_DEF = 64'h1D;

  // Segment length: the 2*op_w chain split evenly across the parallel chains.
  function automatic int unsigned seg_len(input int unsigned op_w, input int unsigned chains);
    return (2 * op_w) / chains;
  endfunction

endpackage

// File: rtl/scan_seg.sv
// One S-bit scan segment: right-shifting serial path or parallel capture.
module scan_seg #(
  parameter int unsigned S = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_shift,
  input  logic         i_cap,
  input  logic         i_si,
  input  logic [S-1:0] i_pi,
  output logic         o_so,
  output logic [S-1:0] o_q
);

  logic [S-1:0] r_q;
  logic [S:0]   w_ext;
  logic [S-1:0] w_d;

  // Widening by one bit keeps the shift expression legal for S == 1.
  assign w_ext = {i_si, r_q};

  always_comb begin
    w_d = r_q;
    if (i_shift) begin
      w_d = w_ext[S:1];
    end else if (i_cap) begin
      w_d = i_pi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_so = r_q[0];
  assign o_q  = r_q;

endmodule

// File: rtl/scan_mult_ctrl.sv
// Scan-chain multiplier with load/capture/unload FSM on valid/ready streams.
// Optional MISR response compaction is enabled by defining SCAN_MISR_EN.
module scan_mult_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned         OP_W      = 4,
  parameter int unsigned         CHAINS    = 1,
  parameter logic [2*OP_W-1:0]   MISR_POLY = MISR_POLY_DEF[2*OP_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pat_valid,
  output logic              pat_ready,
  input  logic [2*OP_W-1:0] pat_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*OP_W-1:0] res_data,
  output logic              busy,
  output logic [2*OP_W-1:0] sig,
  input  logic              sig_clr
);

  localparam int unsigned L  = 2 * OP_W;
  localparam int unsigned S  = seg_len(OP_W, CHAINS);
  localparam int unsigned CW = $clog2(S) + 1;

  scan_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [L-1:0]  r_pat;
  logic [L-1:0]  r_acc;
  logic [L-1:0]  r_res;
  logic          r_res_valid;
  logic          r_busy;
  logic          r_unl;

  logic [L-1:0]      w_chain;
  logic [L-1:0]      w_a;
  logic [L-1:0]      w_b;
  logic [L-1:0]      w_prod;
  logic [L-1:0]      w_pat_nxt;
  logic [L-1:0]      w_acc_nxt;
  logic [CHAINS-1:0] w_so;
  logic [CHAINS-1:0] w_si;
  logic              w_shift;
  logic              w_cap;
  logic              w_last;
  logic              w_done;
  logic              w_free;

  assign w_shift = (r_state == SHIFT) || (r_state == UNLOAD);
  assign w_cap   = (r_state == CAPT);
  assign w_last  = w_shift && (r_cnt == CW'(S - 1));
  assign w_done  = w_last && ((r_state == UNLOAD) || r_unl);
  assign w_free  = !r_res_valid || res_ready;

  assign w_a    = {{OP_W{1'b0}}, w_chain[L-1:OP_W]};
  assign w_b    = {{OP_W{1'b0}}, w_chain[OP_W-1:0]};
  assign w_prod = w_a * w_b;

  // Pattern and unload buffers mirror the segment shift direction, so each
  // bit lands at the chain position it occupies (pattern) or came from (response).
  genvar c;
  generate
    for (c = 0; c < CHAINS; c++) begin : g_seg
      logic [S:0] w_pat_ext;
      logic [S:0] w_acc_ext;

      assign w_si[c]    = (r_state == SHIFT) ? r_pat[c*S] : 1'b0;
      assign w_pat_ext  = {1'b0, r_pat[c*S +: S]};
      assign w_acc_ext  = {w_so[c], r_acc[c*S +: S]};
      assign w_pat_nxt[c*S +: S] = w_pat_ext[S:1];
      assign w_acc_nxt[c*S +: S] = w_acc_ext[S:1];

      scan_seg #(.S(S)) u_seg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_shift (w_shift),
        .i_cap   (w_cap),
        .i_si    (w_si[c]),
        .i_pi    (w_prod[c*S +: S]),
        .o_so    (w_so[c]),
        .o_q     (w_chain[c*S +: S])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pat       <= '0;
      r_acc       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_unl       <= 1'b0;
    end else begin
      if (w_shift) begin
        r_acc <= w_acc_nxt;
      end

      if (w_done) begin
        r_res       <= w_acc_nxt;
        r_res_valid <= 1'b1;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (pat_valid) begin
            r_pat   <= pat_data;
            r_unl   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_pat <= w_pat_nxt;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= CAPT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        CAPT: begin
          r_state <= FULL;
        end
        FULL: begin
          if (w_free) begin
            if (pat_valid) begin
              r_pat   <= pat_data;
              r_unl   <= 1'b1;
              r_state <= SHIFT;
            end else begin
              r_state <= UNLOAD;
            end
          end
        end
        UNLOAD: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pat_ready = rst_n && ((r_state == IDLE) || ((r_state == FULL) && w_free));
  assign res_valid = r_res_valid;
  assign res_data  = r_res;
  assign busy      = r_busy;

`ifdef SCAN_MISR_EN
  logic [L-1:0] r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (sig_clr) begin
      r_sig <= '0;
    end else if (w_done) begin
      r_sig <= {r_sig[L-2:0], 1'b0} ^ (r_sig[L-1] ? MISR_POLY : '0) ^ w_acc_nxt;
    end
  end

  assign sig = r_sig;
`else
  logic w_unused;

  assign w_unused = sig_clr ^ (^MISR_POLY);
  assign sig      = '0;
`endif

endmodule
